// File: rtl/parity_checker.sv
// parity_checker: checks even byte-lane parity on a 32-bit word, forwards it through a
// one-stage valid/ready slice, and tracks a saturating error count plus link health.
module parity_checker #(
    parameter int CNT_W       = 16,
    parameter int FAIL_THRESH = 4,
    parameter int RECOVER_CNT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      din,
    input  logic [3:0]       parity,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      dout,
    output logic [3:0]       err_lanes,
    output logic             err,
    output logic [CNT_W-1:0] err_count,
    output logic [1:0]       link_state,
    input  logic             clr
);
    localparam logic [1:0]       ST_GOOD   = 2'd0;
    localparam logic [1:0]       ST_DEG    = 2'd1;
    localparam logic [1:0]       ST_FAIL   = 2'd2;
    localparam logic [7:0]       FAIL_T    = 8'(FAIL_THRESH);
    localparam logic [7:0]       RECOVER_T = 8'(RECOVER_CNT);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    logic             out_valid_q, out_valid_d;
    logic [31:0]      dout_q, dout_d;
    logic [3:0]       lanes_q, lanes_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       state_q, state_d;
    logic [7:0]       bad_q, bad_d, good_q, good_d;
    logic [3:0]       lane_err;
    logic             accept, word_err;
    logic [7:0]       bad_inc, good_inc;

    always_comb begin
        for (int k = 0; k < 4; k++) lane_err[k] = parity[k] ^ (^din[8*k +: 8]);
    end

    assign word_err = |lane_err;
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign bad_inc  = bad_q + 8'd1;
    assign good_inc = good_q + 8'd1;

    always_comb begin
        out_valid_d = accept ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
        dout_d      = accept ? din : dout_q;
        lanes_d     = accept ? lane_err : lanes_q;
        err_d       = accept ? word_err : err_q;
    end

    // clr outranks a same-cycle accept: that word is forwarded but neither counted nor judged
    always_comb begin
        state_d = state_q;
        bad_d   = bad_q;
        good_d  = good_q;
        cnt_d   = cnt_q;
        if (clr) begin
            state_d = ST_GOOD;
            bad_d   = '0;
            good_d  = '0;
            cnt_d   = '0;
        end else if (accept) begin
            cnt_d = (word_err && cnt_q != CNT_MAX) ? cnt_q + CNT_W'(1) : cnt_q;
            case (state_q)
                ST_GOOD: begin
                    if (word_err) begin
                        state_d = ST_DEG;
                        bad_d   = 8'd1;
                        good_d  = '0;
                    end
                end
                ST_DEG: begin
                    if (word_err) begin
                        bad_d   = bad_inc;
                        good_d  = '0;
                        state_d = (bad_inc == FAIL_T) ? ST_FAIL : ST_DEG;
                    end else if (good_inc == RECOVER_T) begin
                        state_d = ST_GOOD;
                        bad_d   = '0;
                        good_d  = '0;
                    end else begin
                        bad_d  = '0;
                        good_d = good_inc;
                    end
                end
                ST_FAIL: state_d = ST_FAIL;
                default: state_d = ST_GOOD;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            lanes_q     <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            state_q     <= ST_GOOD;
            bad_q       <= '0;
            good_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            dout_q      <= dout_d;
            lanes_q     <= lanes_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            bad_q       <= bad_d;
            good_q      <= good_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign dout       = dout_q;
    assign err_lanes  = lanes_q;
    assign err        = err_q;
    assign err_count  = cnt_q;
    assign link_state = state_q;
endmodule

// File: tb/tb_parity_checker.sv
// tb_parity_checker: directed table-driven bench for parity_checker, plus hand sequences
// for back-pressure, counter saturation (CNT_W=2 instance) and asynchronous reset.
module tb_parity_checker;
    logic        clk, rst_n, in_valid, out_ready, clr;
    logic [31:0] din;
    logic [3:0]  parity;
    logic        in_ready, out_valid, err;
    logic [31:0] dout;
    logic [3:0]  err_lanes;
    logic [15:0] err_count;
    logic [1:0]  link_state;
    logic        in_ready2, out_valid2, err2;
    logic [31:0] dout2;
    logic [3:0]  err_lanes2;
    logic [1:0]  err_count2;
    logic [1:0]  link_state2;
    int checks = 0;
    int errors = 0;

    parity_checker dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .din(din), .parity(parity), .out_valid(out_valid), .out_ready(out_ready),
        .dout(dout), .err_lanes(err_lanes), .err(err), .err_count(err_count),
        .link_state(link_state), .clr(clr)
    );

    parity_checker #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .din(din), .parity(parity), .out_valid(out_valid2), .out_ready(out_ready),
        .dout(dout2), .err_lanes(err_lanes2), .err(err2), .err_count(err_count2),
        .link_state(link_state2), .clr(clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          rep;
        logic        clr;
        logic [31:0] din;
        logic [3:0]  par;
        logic [3:0]  lanes;
        logic [15:0] cnt;
        logic [1:0]  st;
    } vec_t;

    vec_t vecs[21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, " dout"}, dout, 32'd0);
        chk({tag, " err_lanes"}, 32'(err_lanes), 32'd0);
        chk({tag, " err"}, 32'(err), 32'd0);
        chk({tag, " err_count"}, 32'(err_count), 32'd0);
        chk({tag, " link_state"}, 32'(link_state), 32'd0);
        chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        // A = 0x12345678 has clean parity 4'b0100; B = 0xFF00FF01 has clean parity 4'b0001
        vecs[0]  = '{1,  1'b0, 32'h12345678, 4'b0100, 4'b0000, 16'd0, 2'd0};
        vecs[1]  = '{1,  1'b0, 32'h12345678, 4'b0101, 4'b0001, 16'd1, 2'd1};
        vecs[2]  = '{1,  1'b0, 32'h12345678, 4'b1011, 4'b1111, 16'd2, 2'd1};
        vecs[3]  = '{1,  1'b1, 32'h12345678, 4'b0100, 4'b0000, 16'd0, 2'd0};
        vecs[4]  = '{1,  1'b0, 32'h12345678, 4'b0110, 4'b0010, 16'd1, 2'd1};
        vecs[5]  = '{1,  1'b0, 32'h12345678, 4'b0000, 4'b0100, 16'd2, 2'd1};
        vecs[6]  = '{1,  1'b0, 32'h12345678, 4'b1100, 4'b1000, 16'd3, 2'd1};
        vecs[7]  = '{1,  1'b0, 32'h12345678, 4'b0101, 4'b0001, 16'd4, 2'd2};
        vecs[8]  = '{20, 1'b0, 32'h12345678, 4'b0100, 4'b0000, 16'd4, 2'd2};
        vecs[9]  = '{1,  1'b1, 32'h12345678, 4'b0100, 4'b0000, 16'd0, 2'd0};
        vecs[10] = '{1,  1'b0, 32'h12345678, 4'b0101, 4'b0001, 16'd1, 2'd1};
        vecs[11] = '{7,  1'b0, 32'h12345678, 4'b0100, 4'b0000, 16'd1, 2'd1};
        vecs[12] = '{1,  1'b0, 32'h12345678, 4'b0100, 4'b0000, 16'd1, 2'd0};
        vecs[13] = '{1,  1'b0, 32'h12345678, 4'b0101, 4'b0001, 16'd2, 2'd1};
        vecs[14] = '{5,  1'b0, 32'h12345678, 4'b0100, 4'b0000, 16'd2, 2'd1};
        vecs[15] = '{1,  1'b0, 32'h12345678, 4'b0101, 4'b0001, 16'd3, 2'd1};
        vecs[16] = '{7,  1'b0, 32'h12345678, 4'b0100, 4'b0000, 16'd3, 2'd1};
        vecs[17] = '{1,  1'b0, 32'h12345678, 4'b0100, 4'b0000, 16'd3, 2'd0};
        vecs[18] = '{1,  1'b0, 32'hFF00FF01, 4'b0001, 4'b0000, 16'd3, 2'd0};
        vecs[19] = '{1,  1'b0, 32'hFF00FF01, 4'b1110, 4'b1111, 16'd4, 2'd1};
        vecs[20] = '{1,  1'b1, 32'hFF00FF01, 4'b1110, 4'b1111, 16'd0, 2'd0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr = 1'b0;
        din = '0; parity = '0;
        #3;
        check_reset_values("reset");
        rst_n = 1'b1;

        in_valid = 1'b1;
        for (int i = 0; i < 21; i++) begin
            for (int r = 0; r < vecs[i].rep; r++) begin
                clr = vecs[i].clr; din = vecs[i].din; parity = vecs[i].par;
                step();
                chk($sformatf("v%0d.%0d dout", i, r), dout, vecs[i].din);
                chk($sformatf("v%0d.%0d lanes", i, r), 32'(err_lanes), 32'(vecs[i].lanes));
                chk($sformatf("v%0d.%0d err", i, r), 32'(err), 32'(|vecs[i].lanes));
                chk($sformatf("v%0d.%0d valid", i, r), 32'(out_valid), 32'd1);
                chk($sformatf("v%0d.%0d count", i, r), 32'(err_count), 32'(vecs[i].cnt));
                chk($sformatf("v%0d.%0d state", i, r), 32'(link_state), 32'(vecs[i].st));
            end
        end
        clr = 1'b0;

        // drain the slice
        in_valid = 1'b0;
        step();
        chk("drain valid", 32'(out_valid), 32'd0);
        chk("drain in_ready", 32'(in_ready), 32'd1);

        // back-pressure: one error word accepted, then held for 4 more stalled cycles
        in_valid = 1'b1; out_ready = 1'b0;
        din = 32'hA5A5A5A5; parity = 4'b0011;
        step();
        chk("bp accept dout", dout, 32'hA5A5A5A5);
        chk("bp accept count", 32'(err_count), 32'd1);
        din = 32'h0F0F0F0F; parity = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("bp%0d in_ready", c), 32'(in_ready), 32'd0);
            step();
            chk($sformatf("bp%0d dout", c), dout, 32'hA5A5A5A5);
            chk($sformatf("bp%0d lanes", c), 32'(err_lanes), 32'h3);
            chk($sformatf("bp%0d count", c), 32'(err_count), 32'd1);
            chk($sformatf("bp%0d state", c), 32'(link_state), 32'd1);
            chk($sformatf("bp%0d valid", c), 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp release in_ready", 32'(in_ready), 32'd1);
        step();
        chk("bp release dout", dout, 32'h0F0F0F0F);
        chk("bp release lanes", 32'(err_lanes), 32'hF);
        chk("bp release count", 32'(err_count), 32'd2);

        // saturation on the CNT_W=2 instance
        in_valid = 1'b0; clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr count", 32'(err_count), 32'd0);
        chk("clr count2", 32'(err_count2), 32'd0);
        in_valid = 1'b1; din = 32'h12345678; parity = 4'b0101;
        for (int c = 0; c < 5; c++) begin
            step();
            chk($sformatf("sat%0d count2", c), 32'(err_count2), (c < 3) ? 32'(c + 1) : 32'd3);
            chk($sformatf("sat%0d count", c), 32'(err_count), 32'(c + 1));
            chk($sformatf("sat%0d state", c), 32'(link_state), (c < 3) ? 32'd1 : 32'd2);
        end

        // asynchronous reset between edges with a word in the slice
        in_valid = 1'b0; out_ready = 1'b0;
        #2;
        chk("pre-reset valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_values("async reset");
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1; in_valid = 1'b1; din = 32'h12345678; parity = 4'b0100;
        step();
        chk("post-reset dout", dout, 32'h12345678);
        chk("post-reset valid", 32'(out_valid), 32'd1);
        chk("post-reset count", 32'(err_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/parity_checker.md
# parity_checker

Receive-side companion of the byte-lane parity generator. Takes a 32-bit word plus 4 even-parity bits (one per byte), checks each lane and forwards the word through a one-stage valid/ready register slice with per-lane error flags. Also keeps a saturating error-word counter and a link-health state machine. Sits at the sink end of any path protected by the parity generator.

## Interface
- `CNT_W`, 16: width of `err_count`.
- `FAIL_THRESH`, 4: consecutive erroneous words that move the link to FAILED. Legal range is 2 to 255.
- `RECOVER_CNT`, 8: consecutive clean words that return the link from DEGRADED to GOOD. Legal range is 1 to 255.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `in_valid` in 1: input word valid.
- `in_ready` out 1: slice can accept.
- `din` in 32: data word.
- `parity` in 4: received parity; bit k covers `din[8k+7:8k]`.
- `out_valid` out 1: output word valid.
- `out_ready` in 1: downstream accepts.
- `dout` out 32: registered copy of `din`.
- `err_lanes` out 4: bit k is set when lane k of `dout` failed its check.
- `err` out 1: OR of `err_lanes`.
- `err_count` out CNT_W: count of accepted words with any lane error. Saturates.
- `link_state` out 2: 0 = GOOD, 1 = DEGRADED, 2 = FAILED. Encoding 3 is unused.
- `clr` in 1: synchronous clear of the counter and the FSM.

## Operation
- **Parity convention:** even parity. The expected bit is `^din[8k+7:8k]`. Lane k errs when `parity[k]` differs from the expected bit.
- **Accept:** a word is accepted when `in_valid && in_ready`.
- **Ready:** `in_ready = !out_valid || out_ready`. This is combinational from `out_ready`; no skid buffer.
- **On accept:**
  - `dout`, `err_lanes` and `err` load.
  - `out_valid` sets.
  - The counter and FSM update at the same edge.
- **No accept:** if `out_ready` is high, `out_valid` clears. If `out_ready` is low, all outputs hold.
- **Counter:** `err_count` increments by 1 per accepted word with `err` set, regardless of how many lanes failed. It holds at 2^CNT_W−1.
- **FSM internal counters:** `bad_run` and `good_run`, both 8-bit.
- **FSM transitions:** evaluated only on accepted words.
  - GOOD, error word: go to DEGRADED, `bad_run=1`, `good_run=0`.
  - GOOD, clean word: stay in GOOD.
  - DEGRADED, error word: `bad_run++` and `good_run=0`. When `bad_run` reaches FAIL_THRESH, go to FAILED.
  - DEGRADED, clean word: `bad_run=0` and `good_run++`. When `good_run` reaches RECOVER_CNT, go to GOOD and clear both runs.
  - FAILED: sticky; leaves only via `clr` or reset. Data keeps flowing and `err_count` keeps counting.
- **`clr`:** sets `err_count=0`, the state to GOOD, and both runs to 0.
  - `clr` takes priority over a same-cycle accept for the counter and FSM: that word is not counted.
  - The word's `dout` and `err_lanes` still load normally.
- **Reset:** forces all outputs and internal state to 0 immediately, independent of `clk`.
  - `out_valid=0` and `link_state=GOOD` take effect at once.
  - A word in the slice when reset asserts is dropped.

## Timing
- Latency is 1 cycle: a word accepted at edge N is visible on `dout` / `err_lanes` / `err` after edge N. `err_count` and `link_state` reflect it after the same edge.
- Throughput is 1 word per cycle while `out_ready` stays high.
- `in_ready` is combinational from `out_ready`.
- All other outputs are registered.
- Reset values:
  - `dout=0`, `err_lanes=0`, `err=0`.
  - `out_valid=0`, `err_count=0`, `link_state=0`.
  - `in_ready=1`, because `out_valid=0`.
- Back-pressure:
  - With `out_valid=1` and `out_ready=0`, `in_ready=0`. `dout` and the flags are stable, and the FSM and counter do not change.
  - A stalled word is never re-counted.

## Test plan
- **Clean word:** `din=0x12345678`, `parity=4'b0100` → next cycle `dout=0x12345678`, `err_lanes=0`, `err=0`, `err_count=0`, `link_state=0`.
- **Lane errors:** same `din` with `parity=4'b0101` → `err_lanes=4'b0001`, `err=1`, `err_count=1`, `link_state=1`. Then `parity=4'b1011` → `err_lanes=4'b1111`, `err_count=2` (not +4).
- **Failure and clear:** 4 consecutive error words at defaults → `link_state` reads 1,1,1,2 after each. 20 clean words afterwards → it stays 2. Pulse `clr` → `err_count=0`, `link_state=0`.
- **Recovery:** 1 error word, then 7 clean words → `link_state=1`. The 8th clean word → 0. Repeat with an error injected after the 5th clean word → `good_run` restarts and the link stays 1 until 8 more clean words.
- **Back-pressure and saturation:**
  - Hold `out_ready=0` for 5 cycles with `in_valid=1` carrying an error word → `in_ready=0`, `err_count` rises by exactly 1, `dout` stable. Release → next word is accepted the same cycle.
  - With `CNT_W=2`, 5 error words → `err_count=3`.
- **Reset mid-stream and clr collision:**
  - Assert `rst_n=0` between edges with `out_valid=1` → `out_valid` and all flags drop to 0 before the next edge.
  - `clr` coinciding with an error word → `err_count=0`, `link_state=0`, `err_lanes` still set for that word.
